// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: opcodes, FSM states, default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_RSV3 = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high during the final step; product then already holds the
// completed a*b so the caller can register it on that same edge.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;

  assign busy    = (count != '0);
  assign done    = (count == CW'(1));
  assign product = acc + (mplier[0] ? mcand : '0);

  // Load operands on start, then one add-and-shift step per cycle until count hits 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CW'(WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle ops with 1-cycle latency,
// plus an iterative MUL that stalls the issuer via in_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  state_t state, state_next;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign in_ready  = (state == ST_IDLE) && !mul_busy && !reset;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  assign sum     = a + b;
  assign diff    = a + ~b + WIDTH'(1);
  assign ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle operation results and overflow flag.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = sum;  alu_ovf = ovf_add; end
      OP_SUB:  begin alu_res = diff; alu_ovf = ovf_sub; end
      OP_SRL:  alu_res = b >> shamt;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      // Signed less-than corrected for subtraction overflow.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
      OP_SLL:  alu_res = b << shamt;
      OP_XOR:  alu_res = a ^ b;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // FSM next-state: leave IDLE on a MUL accept, return when the multiplier finishes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_start) state_next = ST_MUL;
      ST_MUL:  if (mul_done)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output register stage; values hold until the next completed operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && (op != OP_MUL)) begin
        out_valid <= 1'b1;
        result_lo <= alu_res;
        result_hi <= '0;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
      end else if (mul_done) begin
        out_valid <= 1'b1;
        result_lo <= mul_product[WIDTH-1:0];
        result_hi <= mul_product[2*WIDTH-1:WIDTH];
        zero      <= (mul_product[WIDTH-1:0] == '0);
        ovf       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=16 against a plain-arithmetic model.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    shamt;
  logic          out_valid;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          zero;
  logic          ovf;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference model from the operation definitions using integer arithmetic.
  function automatic void model(input logic [3:0] mop, input logic [15:0] ma, input logic [15:0] mb,
                                input logic [3:0] msh, output logic [15:0] lo, output logic [15:0] hi,
                                output logic z, output logic o);
    int sa, sb, ua, ub, full;
    longint p;
    logic [31:0] pv;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    lo = 16'h0; hi = 16'h0; o = 1'b0;
    case (mop)
      4'd0: begin full = sa + sb; lo = 16'((ua + ub) % 65536); o = (full > 32767) || (full < -32768); end
      4'd1: begin full = sa - sb; lo = 16'((ua - ub + 65536) % 65536); o = (full > 32767) || (full < -32768); end
      4'd2: lo = 16'(ub / (1 << msh));
      4'd4: lo = ma & mb;
      4'd5: lo = ma | mb;
      4'd6: lo = (sa < sb) ? 16'd1 : 16'd0;
      4'd7: lo = 16'((ub * (1 << msh)) % 65536);
      4'd8: begin p = longint'(ua) * longint'(ub); pv = 32'(p); lo = pv[15:0]; hi = pv[31:16]; end
      4'd9: lo = ma ^ mb;
      4'd10: lo = 16'(sb >>> msh);
      4'd11: lo = (ua < ub) ? 16'd1 : 16'd0;
      default: lo = 16'h0;
    endcase
    z = (lo == 16'h0);
  endfunction

  localparam int ND = 13;
  localparam logic [3:0]  D_OP [ND] = '{4'd0, 4'd1, 4'd6, 4'd11, 4'd2, 4'd7, 4'd10, 4'd2, 4'd10, 4'd1, 4'd3, 4'd12, 4'd9};
  localparam logic [15:0] D_A  [ND] = '{16'h7FFF, 16'h0005, 16'h8000, 16'h8000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hF0F0};
  localparam logic [15:0] D_B  [ND] = '{16'h0001, 16'h0005, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h0001, 16'h8000, 16'hABCD, 16'h8123, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFF00};
  localparam logic [3:0]  D_SH [ND] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd15, 4'd3, 4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 4'd0};
  localparam logic [15:0] D_LO [ND] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h0800, 16'h8000, 16'hF000, 16'hABCD, 16'h8123, 16'h7FFF, 16'h0000, 16'h0000, 16'h0FF0};
  localparam logic        D_Z  [ND] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic        D_O  [ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; op = 4'd0; a = 16'h1234; b = 16'h1111; shamt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result_lo !== 16'h0 || result_hi !== 16'h0 || zero !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b lo=%h hi=%h z=%b o=%b, want all 0", out_valid, result_lo, result_hi, zero, ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < ND; i++) begin
      in_valid = 1'b1; op = D_OP[i]; a = D_A[i]; b = D_B[i]; shamt = D_SH[i];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result_lo !== D_LO[i] || result_hi !== 16'h0 || zero !== D_Z[i] || ovf !== D_O[i]) begin
        failures++;
        $display("FAIL directed_%0d op=%h: got v=%b lo=%h hi=%h z=%b o=%b want v=1 lo=%h hi=0 z=%b o=%b",
                 i, D_OP[i], out_valid, result_lo, result_hi, zero, ovf, D_LO[i], D_Z[i], D_O[i]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result_lo !== D_LO[ND-1]) begin
      failures++;
      $display("FAIL directed_hold: got v=%b lo=%h want v=0 lo=%h", out_valid, result_lo, D_LO[ND-1]);
    end
  endtask

  task automatic test_random_single();
    logic [15:0] elo, ehi; logic ez, eo;
    for (int i = 0; i < 80; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd8);
      a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
      if (i % 5 == 0) b = a;
      in_valid = 1'b1;
      model(op, a, b, shamt, elo, ehi, ez, eo);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result_lo !== elo || result_hi !== ehi || zero !== ez || ovf !== eo) begin
        failures++;
        $display("FAIL random_%0d op=%h a=%h b=%h sh=%0d: got v=%b lo=%h hi=%h z=%b o=%b want v=1 lo=%h hi=%h z=%b o=%b",
                 i, op, a, b, shamt, out_valid, result_lo, result_hi, zero, ovf, elo, ehi, ez, eo);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_busy();
    in_valid = 1'b1; op = 4'd8; a = 16'hFFFF; b = 16'hFFFF; shamt = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mul_busy_%0d: got rdy=%b v=%b want rdy=0 v=0", i, in_ready, out_valid);
      end
      op = 4'd0; a = 16'h0001; b = 16'h0001;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || result_hi !== 16'hFFFE || result_lo !== 16'h0001 || zero !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL mul_result: got v=%b rdy=%b hi=%h lo=%h z=%b o=%b want v=1 rdy=1 hi=fffe lo=0001 z=0 o=0",
               out_valid, in_ready, result_hi, result_lo, zero, ovf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result_lo !== 16'h0001 || result_hi !== 16'hFFFE) begin
      failures++;
      $display("FAIL mul_ignored_add: got v=%b lo=%h hi=%h want v=0 lo=0001 hi=fffe", out_valid, result_lo, result_hi);
    end
  endtask

  task automatic test_mul_random();
    logic [15:0] elo, ehi; logic ez, eo;
    int lat;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i == 0) a = 16'h0;
      op = 4'd8; shamt = '0; in_valid = 1'b1;
      model(4'd8, a, b, 4'd0, elo, ehi, ez, eo);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || lat != 17 || result_lo !== elo || result_hi !== ehi || zero !== ez || ovf !== 1'b0) begin
        failures++;
        $display("FAIL mul_rand_%0d a=%h b=%h: got v=%b lat=%0d hi=%h lo=%h z=%b o=%b want v=1 lat=17 hi=%h lo=%h z=%b o=0",
                 i, a, b, out_valid, lat, result_hi, result_lo, zero, ovf, ehi, elo, ez);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mul_reset();
    int seen;
    in_valid = 1'b1; op = 4'd8; a = 16'h1234; b = 16'h0010; shamt = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result_lo !== 16'h0 || result_hi !== 16'h0 || zero !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mul_reset_outputs: got v=%b lo=%h hi=%h z=%b o=%b rdy=%b want all 0",
               out_valid, result_lo, result_hi, zero, ovf, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mul_reset_ready: got %b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mul_reset_discard: got %0d out_valid pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] elo, ehi, mlo, mhi; logic ez, eo, mz, mo;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 4'd0; a = 16'($urandom); b = 16'($urandom); shamt = '0;
      model(4'd0, a, b, 4'd0, elo, ehi, ez, eo);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result_lo !== elo || ovf !== eo || zero !== ez) begin
        failures++;
        $display("FAIL b2b_add_%0d: got v=%b lo=%h z=%b o=%b want v=1 lo=%h z=%b o=%b",
                 i, out_valid, result_lo, zero, ovf, elo, ez, eo);
      end
    end
    op = 4'd8; a = 16'($urandom); b = 16'($urandom);
    model(4'd8, a, b, 4'd0, mlo, mhi, mz, mo);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_mul_busy: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || result_lo !== mlo || result_hi !== mhi) begin
      failures++;
      $display("FAIL b2b_mul: got v=%b rdy=%b hi=%h lo=%h want v=1 rdy=1 hi=%h lo=%h",
               out_valid, in_ready, result_hi, result_lo, mhi, mlo);
    end
    in_valid = 1'b1; op = 4'd0; a = 16'($urandom); b = 16'($urandom);
    model(4'd0, a, b, 4'd0, elo, ehi, ez, eo);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result_lo !== elo || result_hi !== 16'h0 || ovf !== eo) begin
      failures++;
      $display("FAIL b2b_post_mul_add: got v=%b lo=%h hi=%h o=%b want v=1 lo=%h hi=0 o=%b",
               out_valid, result_lo, result_hi, ovf, elo, eo);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random_single();
    test_mul_busy();
    test_mul_random();
    test_mul_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
